// File: rtl/main_mem_responder_if.sv
// Byte-serial main-memory bus plus host RX/TX byte streams and halt outputs.
// Master = memory controller / host side, slave = main_mem_responder.
// Pure signal bundle; no logic.
interface main_mem_responder_if;
  // memory controller side
  logic        mem_valid;
  logic        mmem_r_w;
  logic [31:0] mmem_addr;
  logic [7:0]  mmem_data;
  logic [7:0]  data_get;
  // host -> CPU byte stream
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  // CPU -> host byte stream
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  // halt request
  logic        sim_halt;
  logic [7:0]  halt_code;

  modport master (
    output mem_valid, mmem_r_w, mmem_addr, mmem_data, rx_valid, rx_data, tx_ready,
    input  data_get, rx_ready, tx_valid, tx_data, sim_halt, halt_code
  );

  modport slave (
    input  mem_valid, mmem_r_w, mmem_addr, mmem_data, rx_valid, rx_data, tx_ready,
    output data_get, rx_ready, tx_valid, tx_data, sim_halt, halt_code
  );
endinterface

// File: rtl/main_mem_responder.sv
// Responder for the byte-serial main-memory bus: RAM array plus an IO window
// (RX/TX byte FIFOs, status, halt). One byte per clock, data_get registered (1 cycle).
// Optional MEM_RESP_PERF_EN adds RAM read/write access counters at IO offsets 0x8-0xF.

// Circular byte FIFO, pointers one bit wider than the index so full/empty
// come from the MSB compare. Push when full and pop when empty are ignored;
// the head reads as zero while empty.
module mmr_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_push_dat,
  input  logic       i_pop,
  output logic [7:0] o_head_dat,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [DEPTH];
  logic        w_push_ok;
  logic        w_pop_ok;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok  = i_push && !o_full;
  assign w_pop_ok   = i_pop && !o_empty;
  assign o_head_dat = o_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; both pointers wrap modulo 2*DEPTH naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end
endmodule

module main_mem_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h30000,
  parameter int          RX_DEPTH   = 16,
  parameter int          TX_DEPTH   = 16
) (
  input logic                i_clk,
  input logic                i_rst_n,
  main_mem_responder_if.slave bus_if
);
  // address decode
  logic                  w_is_io;
  logic [3:0]            w_off;
  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic                  w_io_rd;
  logic                  w_io_wr;
  logic                  w_ram_rd;
  logic                  w_ram_wr;

  // FIFO plumbing
  logic                  w_rx_pop;
  logic [7:0]            w_rx_head;
  logic                  w_rx_full;
  logic                  w_rx_empty;
  logic                  w_tx_push;
  logic [7:0]            w_tx_head;
  logic                  w_tx_full;
  logic                  w_tx_empty;

  // read path
  logic [7:0]            w_io_byte;
  logic [7:0]            w_rd_byte;
  logic [7:0]            w_status;

  // state
  logic [7:0]            r_ram [2**ADDR_WIDTH];
  logic [7:0]            r_data_get;
  logic                  r_tx_ovf;
  logic                  r_sim_halt;
  logic [7:0]            r_halt_code;

  assign w_is_io   = (bus_if.mmem_addr >= IO_BASE);
  assign w_off     = bus_if.mmem_addr[3:0];
  assign w_ram_idx = bus_if.mmem_addr[ADDR_WIDTH-1:0];
  assign w_io_rd   = bus_if.mem_valid && !bus_if.mmem_r_w && w_is_io;
  assign w_io_wr   = bus_if.mem_valid &&  bus_if.mmem_r_w && w_is_io;
  assign w_ram_rd  = bus_if.mem_valid && !bus_if.mmem_r_w && !w_is_io;
  assign w_ram_wr  = bus_if.mem_valid &&  bus_if.mmem_r_w && !w_is_io;

  // Pop on empty and push on full are ignored inside the FIFO.
  assign w_rx_pop  = w_io_rd && (w_off == 4'h0);
  assign w_tx_push = w_io_wr && (w_off == 4'h0);

  mmr_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (bus_if.rx_valid),
    .i_push_dat (bus_if.rx_data),
    .i_pop      (w_rx_pop),
    .o_head_dat (w_rx_head),
    .o_full     (w_rx_full),
    .o_empty    (w_rx_empty)
  );

  mmr_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_tx_push),
    .i_push_dat (bus_if.mmem_data),
    .i_pop      (bus_if.tx_ready),
    .o_head_dat (w_tx_head),
    .o_full     (w_tx_full),
    .o_empty    (w_tx_empty)
  );

  assign bus_if.rx_ready  = !w_rx_full;
  assign bus_if.tx_valid  = !w_tx_empty;
  assign bus_if.tx_data   = w_tx_head;
  assign bus_if.data_get  = r_data_get;
  assign bus_if.sim_halt  = r_sim_halt;
  assign bus_if.halt_code = r_halt_code;

  assign w_status = {4'b0000, r_tx_ovf, r_sim_halt, w_tx_full, w_rx_empty};

`ifdef MEM_RESP_PERF_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;
  logic [31:0] w_perf_word;
  logic [31:0] w_perf_shift;

  assign w_perf_word  = w_off[2] ? r_wr_cnt : r_rd_cnt;
  assign w_perf_shift = w_perf_word >> {w_off[1:0], 3'b000};

  // Wrapping RAM access counters; IO accesses are not counted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_ram_rd) r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_ram_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  // IO read mux; head/status/counter values, no side effects here.
  always_comb begin
    w_io_byte = 8'h00;
    case (w_off)
      4'h0:    w_io_byte = w_rx_head;
      4'h1:    w_io_byte = w_status;
      4'h8, 4'h9, 4'hA, 4'hB,
      4'hC, 4'hD, 4'hE, 4'hF:
               w_io_byte = w_perf_shift[7:0];
      default: w_io_byte = 8'h00;
    endcase
  end
`else
  // RAM read strobe only feeds the optional counters.
  logic w_ram_rd_unused;
  assign w_ram_rd_unused = w_ram_rd;

  // IO read mux; head/status values, no side effects here.
  always_comb begin
    w_io_byte = 8'h00;
    case (w_off)
      4'h0:    w_io_byte = w_rx_head;
      4'h1:    w_io_byte = w_status;
      default: w_io_byte = 8'h00;
    endcase
  end
`endif

  assign w_rd_byte = w_is_io ? w_io_byte : r_ram[w_ram_idx];

  // Registered read data every cycle, independent of mem_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_data_get <= 8'h00;
    else          r_data_get <= w_rd_byte;
  end

  // RAM write; the read above sees the old byte on a same-index collision.
  always_ff @(posedge i_clk) begin
    if (w_ram_wr) r_ram[w_ram_idx] <= bus_if.mmem_data;
  end

  // Sticky TX overflow flag and halt request registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_ovf    <= 1'b0;
      r_sim_halt  <= 1'b0;
      r_halt_code <= 8'h00;
    end else begin
      if (w_tx_push && w_tx_full)           r_tx_ovf <= 1'b1;
      else if (w_io_wr && (w_off == 4'h1))  r_tx_ovf <= 1'b0;
      if (w_io_wr && (w_off == 4'h4)) begin
        r_sim_halt  <= 1'b1;
        r_halt_code <= bus_if.mmem_data;
      end
    end
  end
endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder against a queue/array model.
module tb_main_mem_responder;
  localparam logic [31:0] IO_BASE = 32'h30000;
  localparam int          DEPTH   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  main_mem_responder_if u_if ();

  main_mem_responder #(
    .ADDR_WIDTH (17),
    .IO_BASE    (32'h30000),
    .RX_DEPTH   (DEPTH),
    .TX_DEPTH   (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus_if  (u_if)
  );

  // reference model state
  logic [7:0]  m_ram [int];
  logic [7:0]  rx_q [$];
  logic [7:0]  tx_q [$];
  bit          m_ovf;
  bit          m_halt;
  logic [7:0]  m_code;
  int unsigned m_rd;
  int unsigned m_wr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    m_ovf  = 0;
    m_halt = 0;
    m_code = 8'h00;
    m_rd   = 0;
    m_wr   = 0;
  endtask

  function automatic logic [7:0] io_expect(input logic [3:0] off);
    logic [31:0] word;
    case (off)
      4'h0: return (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      4'h1: return {4'b0000, m_ovf, m_halt, (tx_q.size() == DEPTH), (rx_q.size() == 0)};
`ifdef MEM_RESP_PERF_EN
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: begin
        word = (off >= 4'hC) ? m_wr : m_rd;
        word = word >> (8 * (off % 4));
        return word[7:0];
      end
`endif
      default: begin
        word = 0;
        return word[7:0];
      end
    endcase
  endfunction

  // One bus cycle; host rx_valid/tx_ready levels already set by the caller.
  task automatic do_acc(input logic v, input logic w, input logic [31:0] a,
                        input logic [7:0] d, input string tag);
    logic [7:0] exp;
    bit         known;
    int         idx;
    bit         rx_push;
    bit         tx_pop;
    bit         tx_was_full;
    idx   = int'(a & 32'h1FFFF);
    known = 1;
    exp   = 8'h00;
    if (a >= IO_BASE) exp = io_expect(a[3:0]);
    else if (m_ram.exists(idx)) exp = m_ram[idx];
    else known = 0;
    rx_push     = u_if.rx_valid && (rx_q.size() < DEPTH);
    tx_pop      = u_if.tx_ready && (tx_q.size() > 0);
    tx_was_full = (tx_q.size() == DEPTH);
    u_if.mem_valid = v;
    u_if.mmem_r_w  = w;
    u_if.mmem_addr = a;
    u_if.mmem_data = d;
    cyc();
    if (known) check(tag, u_if.data_get, exp);
    if (v && a < IO_BASE) begin
      if (w) begin
        m_ram[idx] = d;
        m_wr++;
      end else begin
        m_rd++;
      end
    end else if (v) begin
      case (a[3:0])
        4'h0: if (!w && rx_q.size() > 0) void'(rx_q.pop_front());
        4'h1: if (w) m_ovf = 0;
        4'h4: if (w) begin m_halt = 1; m_code = d; end
        default: ;
      endcase
    end
    if (tx_pop) void'(tx_q.pop_front());
    if (v && w && a >= IO_BASE && a[3:0] == 4'h0) begin
      if (tx_was_full) m_ovf = 1;
      else tx_q.push_back(d);
    end
    if (rx_push) rx_q.push_back(u_if.rx_data);
    u_if.mem_valid = 1'b0;
  endtask

  task automatic host_push(input logic [7:0] b);
    u_if.rx_valid = 1'b1;
    u_if.rx_data  = b;
    check("rx_ready", u_if.rx_ready, rx_q.size() < DEPTH);
    do_acc(0, 0, IO_BASE + 32'h2, 8'h00, "idle");
    u_if.rx_valid = 1'b0;
  endtask

  task automatic check_status(input string tag);
    do_acc(1, 0, IO_BASE + 32'h1, 8'h00, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wr_addrs [$];
    int          n;

    u_if.mem_valid = 0; u_if.mmem_r_w = 0; u_if.mmem_addr = 0; u_if.mmem_data = 0;
    u_if.rx_valid  = 0; u_if.rx_data  = 0; u_if.tx_ready  = 0;
    model_reset();
    repeat (3) cyc();
    check("rst_data_get", u_if.data_get, 8'h00);
    check("rst_tx_valid", u_if.tx_valid, 1'b0);
    check("rst_rx_ready", u_if.rx_ready, 1'b1);
    check("rst_sim_halt", u_if.sim_halt, 1'b0);
    check("rst_halt_code", u_if.halt_code, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // basic write then read
    do_acc(1, 1, 32'h10, 8'hA5, "wr10");
    do_acc(1, 0, 32'h10, 8'h00, "rd10");
    // read-before-write collision
    do_acc(1, 1, 32'h20, 8'h11, "wr20a");
    do_acc(1, 1, 32'h20, 8'h3C, "rbw20");
    do_acc(1, 0, 32'h20, 8'h00, "rd20");
    // RAM read without mem_valid still returns data
    do_acc(0, 0, 32'h10, 8'h00, "rd10_nv");

    // randomized RAM traffic incl. aliasing above 2**17
    for (int i = 0; i < 80; i++) begin
      if (wr_addrs.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 32'h2FFFF);
        do_acc(1, 1, a, 8'($urandom), "ram_wr");
        wr_addrs.push_back(a);
      end else begin
        a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
        if ($urandom_range(0, 1) == 1 && a < 32'h10000) a = a + 32'h20000;
        do_acc(1, 0, a, 8'h00, "ram_rd");
      end
    end

    // RX: directed pushes, peek without pop, pops, empty read
    host_push(8'h41);
    host_push(8'h42);
    do_acc(0, 0, IO_BASE, 8'h00, "rx_peek");
    do_acc(1, 0, IO_BASE, 8'h00, "rx_pop1");
    do_acc(1, 0, IO_BASE, 8'h00, "rx_pop2");
    do_acc(1, 0, IO_BASE, 8'h00, "rx_pop_empty");
    check_status("status_rx_empty");
    // push and pop same cycle while empty: pop yields 0, push lands
    u_if.rx_valid = 1'b1;
    u_if.rx_data  = 8'h77;
    do_acc(1, 0, IO_BASE, 8'h00, "rx_pp_empty");
    u_if.rx_valid = 1'b0;
    do_acc(1, 0, IO_BASE, 8'h00, "rx_pp_landed");

    // randomized RX fill past full, then drain
    n = $urandom_range(12, 20);
    for (int i = 0; i < n; i++) host_push(8'($urandom));
    check_status("status_rx_fill");
    // full: same-cycle push blocked, pop lands
    u_if.rx_valid = 1'b1;
    u_if.rx_data  = 8'hEE;
    do_acc(1, 0, IO_BASE, 8'h00, "rx_pp_full");
    u_if.rx_valid = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) do_acc(1, 0, IO_BASE, 8'h00, "rx_drain");

    // TX: 17 writes with host stalled -> overflow
    for (int i = 0; i < DEPTH + 1; i++) do_acc(1, 1, IO_BASE, 8'($urandom), "tx_wr");
    check("tx_valid_full", u_if.tx_valid, 1'b1);
    check_status("status_tx_ovf");
    u_if.tx_ready = 1'b1;
    for (int k = 0; k < 3 * DEPTH && tx_q.size() > 0; k++) begin
      check("tx_valid", u_if.tx_valid, 1'b1);
      check("tx_data", u_if.tx_data, tx_q[0]);
      do_acc(0, 0, IO_BASE + 32'h2, 8'h00, "idle");
    end
    check("tx_drained", tx_q.size(), 0);
    check("tx_valid_empty", u_if.tx_valid, 1'b0);
    u_if.tx_ready = 1'b0;
    check_status("status_pre_clr");
    do_acc(1, 1, IO_BASE + 32'h1, 8'hFF, "ovf_clr");
    check_status("status_clr");

    // unmapped offsets read 0
    do_acc(1, 0, IO_BASE + 32'h3, 8'h00, "io_off3");
    do_acc(1, 1, IO_BASE + 32'h7, 8'h5A, "io_off7_wr");

    // halt
    do_acc(1, 1, IO_BASE + 32'h4, 8'h07, "halt_wr");
    check("sim_halt", u_if.sim_halt, m_halt);
    check("halt_code", u_if.halt_code, m_code);
    check_status("status_halt");
    do_acc(1, 0, 32'h10, 8'h00, "ram_after_halt");

    // reset mid-access: queue a TX byte, then assert reset mid-cycle
    do_acc(1, 1, IO_BASE, 8'h99, "tx_pre_rst");
    u_if.mem_valid = 1'b1;
    u_if.mmem_r_w  = 1'b1;
    u_if.mmem_addr = IO_BASE;
    u_if.mmem_data = 8'h55;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_data_get", u_if.data_get, 8'h00);
    check("mid_rst_tx_valid", u_if.tx_valid, 1'b0);
    check("mid_rst_tx_data", u_if.tx_data, 8'h00);
    check("mid_rst_sim_halt", u_if.sim_halt, 1'b0);
    check("mid_rst_halt_code", u_if.halt_code, 8'h00);
    cyc();
    check("rst_discard_tx", u_if.tx_valid, 1'b0);
    u_if.mem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // counters: 3 RAM reads + 2 RAM writes since reset; RAM kept its contents
    do_acc(1, 0, 32'h10, 8'h00, "perf_rd0");
    do_acc(1, 0, 32'h20, 8'h00, "perf_rd1");
    do_acc(1, 0, 32'h10, 8'h00, "perf_rd2");
    do_acc(1, 1, 32'h30, 8'h12, "perf_wr0");
    do_acc(1, 1, 32'h31, 8'h34, "perf_wr1");
    for (int o = 8; o < 16; o++) do_acc(1, 0, IO_BASE + o, 8'h00, "perf_byte");
    do_acc(1, 1, IO_BASE + 32'h8, 8'hFF, "perf_wr_ign");
    do_acc(1, 0, IO_BASE + 32'h8, 8'h00, "perf_byte_after_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
